writeback_arbiter: RTL and testbench

// Writeback stage directly upstream of the integer register file.

---
 rtl/writeback_arbiter.sv | 157 +++++++++++++++
 tb/tb_writeback_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//
// Writeback stage in front of the integer register file. It merges ALU results
// and load results into at most one register-file write per cycle. Loads are
// buffered in a small FIFO. An ALU result whose destination matches an older,
// still-queued load is held back, so writes to the same register stay in order.
//
// Ports
//   clk                  core clock, all state updates on its rising edge
//   reset                asynchronous reset, active low
//   alu_valid/ready      ALU result handshake; alu_rd/alu_data carry the result
//   mem_valid/ready      load result handshake; mem_rd/mem_data carry the result
//   wrt_high_enable      registered register-file write strobe
//   destn_reg/destn_data registered register-file write address and data
//   busy                 the load FIFO holds at least one entry
//
// Optional feature (define WB_FWD_EN):
//   fwd_reg_A/B          consumer source registers
//   fwd_hit_A/B          the write currently on destn_* targets that register
//   fwd_data_A/B         the value being written (destn_data)
//   These ports let a consumer see a write that the register file has not yet
//   captured.
// -----------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int XLEN     = 64,
  parameter int MQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            wrt_high_enable,
  output logic [4:0]      destn_reg,
  output logic [XLEN-1:0] destn_data,
  output logic            busy
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]      fwd_reg_A,
  input  logic [4:0]      fwd_reg_B,
  output logic            fwd_hit_A,
  output logic            fwd_hit_B,
  output logic [XLEN-1:0] fwd_data_A,
  output logic [XLEN-1:0] fwd_data_B
`endif
);

  localparam int PW = $clog2(MQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(MQ_DEPTH);

  // Load FIFO storage. It has no reset: an entry is only ever read while the
  // count marks it as occupied.
  logic [4:0]      q_rd_mem   [MQ_DEPTH];
  logic [XLEN-1:0] q_data_mem [MQ_DEPTH];

  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;

  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                alu_fire;
  logic                waw_hit;
  logic                sel_valid;
  logic [4:0]          sel_rd;
  logic [XLEN-1:0]     sel_data;
  logic [MQ_DEPTH-1:0] entry_hit;

  assign full      = (count_reg == DEPTH_C);
  assign empty     = (count_reg == '0);
  // Uses registered state only, so a pop in this cycle does not free a slot
  // until the next cycle.
  assign mem_ready = (count_reg < DEPTH_C);
  assign push      = mem_valid && mem_ready;
  assign busy      = !empty;

  // An entry is occupied when its distance from the head is below the count.
  // Pointer subtraction wraps naturally because the depth is a power of two.
  generate
    for (genvar gi = 0; gi < MQ_DEPTH; gi++) begin : g_entry
      logic [PW-1:0] offset;
      assign offset        = PW'(gi) - rd_ptr_reg;
      assign entry_hit[gi] = ({1'b0, offset} < count_reg) && (q_rd_mem[gi] == alu_rd);
    end
  endgenerate

  // Every queued load is older than the ALU result, and so is a load accepted
  // in this same cycle. x0 is never really written, so it never conflicts.
  assign waw_hit   = (alu_rd != 5'd0) &&
                     ((|entry_hit) || (push && (mem_rd == alu_rd)));
  assign alu_ready = !full && !waw_hit;
  assign alu_fire  = alu_valid && alu_ready;

  // Source select. A full FIFO drains first. Otherwise an accepted ALU result
  // wins, and the FIFO uses any cycle the ALU leaves free.
  always_comb begin
    pop       = 1'b0;
    sel_valid = 1'b0;
    sel_rd    = q_rd_mem[rd_ptr_reg];
    sel_data  = q_data_mem[rd_ptr_reg];
    if (full || (!alu_fire && !empty)) begin
      pop       = 1'b1;
      sel_valid = 1'b1;
    end else if (alu_fire) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd_mem[wr_ptr_reg]   <= mem_rd;
      q_data_mem[wr_ptr_reg] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
      wrt_high_enable <= 1'b0;
      destn_reg       <= '0;
      destn_data      <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
      // A selected x0 result still completes and updates destn_*, but it
      // never raises the strobe.
      wrt_high_enable <= sel_valid && (sel_rd != 5'd0);
      if (sel_valid) begin
        destn_reg  <= sel_rd;
        destn_data <= sel_data;
      end
    end
  end

`ifdef WB_FWD_EN
  assign fwd_hit_A  = wrt_high_enable && (destn_reg == fwd_reg_A) && (fwd_reg_A != 5'd0);
  assign fwd_hit_B  = wrt_high_enable && (destn_reg == fwd_reg_B) && (fwd_reg_B != 5'd0);
  assign fwd_data_A = destn_data;
  assign fwd_data_B = destn_data;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;

  logic            clk;
  logic            reset;
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            wrt_high_enable;
  logic [4:0]      destn_reg;
  logic [XLEN-1:0] destn_data;
  logic            busy;
`ifdef WB_FWD_EN
  logic [4:0]      fwd_reg_A;
  logic [4:0]      fwd_reg_B;
  logic            fwd_hit_A;
  logic            fwd_hit_B;
  logic [XLEN-1:0] fwd_data_A;
  logic [XLEN-1:0] fwd_data_B;
`endif

  writeback_arbiter #(.XLEN(XLEN), .MQ_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_rd          (mem_rd),
    .mem_data        (mem_data),
    .wrt_high_enable (wrt_high_enable),
    .destn_reg       (destn_reg),
    .destn_data      (destn_data),
    .busy            (busy)
`ifdef WB_FWD_EN
    ,
    .fwd_reg_A       (fwd_reg_A),
    .fwd_reg_B       (fwd_reg_B),
    .fwd_hit_A       (fwd_hit_A),
    .fwd_hit_B       (fwd_hit_B),
    .fwd_data_A      (fwd_data_A),
    .fwd_data_B      (fwd_data_B)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            mq[$];
  logic            exp_we   = 1'b0;
  logic [4:0]      exp_reg  = '0;
  logic [XLEN-1:0] exp_data = '0;

  function automatic bit model_mem_ready();
    return mq.size() < DEPTH;
  endfunction

  function automatic bit model_alu_ready();
    bit hit;
    hit = 1'b0;
    if (mq.size() == DEPTH) return 1'b0;
    if (alu_rd != 5'd0) begin
      foreach (mq[i]) if (mq[i].rd == alu_rd) hit = 1'b1;
      if (mem_valid && model_mem_ready() && mem_rd == alu_rd) hit = 1'b1;
    end
    return !hit;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      exp_we   = 1'b0;
      exp_reg  = '0;
      exp_data = '0;
    end else begin
      bit   take_load;
      bit   take_alu;
      bit   do_push;
      ent_t w;
      do_push   = mem_valid && model_mem_ready();
      take_load = 1'b0;
      take_alu  = 1'b0;
      if (mq.size() == DEPTH)                 take_load = 1'b1;
      else if (alu_valid && model_alu_ready()) take_alu = 1'b1;
      else if (mq.size() > 0)                 take_load = 1'b1;
      w = '0;
      if (take_load) w = mq.pop_front();
      if (take_alu)  w = '{rd: alu_rd, data: alu_data};
      if (do_push) mq.push_back('{rd: mem_rd, data: mem_data});
      exp_we = (take_load || take_alu) && (w.rd != 5'd0);
      if (take_load || take_alu) begin
        exp_reg  = w.rd;
        exp_data = w.data;
        $display("t=%0t %s result r%0d <= %0h strobe=%0b", $time,
                 take_load ? "load" : "alu", w.rd, w.data, exp_we);
      end
    end
  end

  // ---------------- hand-pinned expectations ----------------
  bit              pin_wr = 1'b0, pin_hs = 1'b0, pin_fwd = 1'b0;
  string           pin_wr_name, pin_hs_name, pin_fwd_name;
  logic            pin_we, pin_alu_ready, pin_mem_ready, pin_busy, pin_hit_a, pin_hit_b;
  logic [4:0]      pin_reg;
  logic [XLEN-1:0] pin_data, pin_fwd_data;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The single compare process: every cycle against the model, plus pins.
  always @(negedge clk) begin
    chk("alu_ready",       alu_ready,       model_alu_ready());
    chk("mem_ready",       mem_ready,       model_mem_ready());
    chk("busy",            busy,            mq.size() != 0);
    chk("wrt_high_enable", wrt_high_enable, exp_we);
    chk("destn_reg",       destn_reg,       exp_reg);
    chk("destn_data",      destn_data,      exp_data);
`ifdef WB_FWD_EN
    chk("fwd_hit_A",  fwd_hit_A,  exp_we && exp_reg == fwd_reg_A && fwd_reg_A != 5'd0);
    chk("fwd_hit_B",  fwd_hit_B,  exp_we && exp_reg == fwd_reg_B && fwd_reg_B != 5'd0);
    chk("fwd_data_A", fwd_data_A, exp_data);
    chk("fwd_data_B", fwd_data_B, exp_data);
    if (pin_fwd) begin
      chk({pin_fwd_name, "/hit_A"},  fwd_hit_A,  pin_hit_a);
      chk({pin_fwd_name, "/hit_B"},  fwd_hit_B,  pin_hit_b);
      chk({pin_fwd_name, "/data_A"}, fwd_data_A, pin_fwd_data);
    end
`endif
    if (pin_wr) begin
      chk({pin_wr_name, "/we"},   wrt_high_enable, pin_we);
      chk({pin_wr_name, "/reg"},  destn_reg,       pin_reg);
      chk({pin_wr_name, "/data"}, destn_data,      pin_data);
    end
    if (pin_hs) begin
      chk({pin_hs_name, "/alu_ready"}, alu_ready, pin_alu_ready);
      chk({pin_hs_name, "/mem_ready"}, mem_ready, pin_mem_ready);
      chk({pin_hs_name, "/busy"},      busy,      pin_busy);
    end
  end

  // ---------------- stimulus ----------------
  task automatic expect_wr(input string name, input logic we, input logic [4:0] rg,
                           input logic [XLEN-1:0] d);
    pin_wr = 1'b1; pin_wr_name = name; pin_we = we; pin_reg = rg; pin_data = d;
  endtask

  task automatic expect_hs(input string name, input logic ar, input logic mr, input logic b);
    pin_hs = 1'b1; pin_hs_name = name; pin_alu_ready = ar; pin_mem_ready = mr; pin_busy = b;
  endtask

  task automatic expect_fwd(input string name, input logic ha, input logic hb,
                            input logic [XLEN-1:0] d);
    pin_fwd = 1'b1; pin_fwd_name = name; pin_hit_a = ha; pin_hit_b = hb; pin_fwd_data = d;
  endtask

  // Drive one cycle of inputs; pins set beforehand are checked at its negedge.
  task automatic go(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                    input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] md);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    @(posedge clk);
    #1;
    pin_wr = 1'b0; pin_hs = 1'b0; pin_fwd = 1'b0;
  endtask

  task automatic idle();
    go(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  initial begin
    reset = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
`ifdef WB_FWD_EN
    fwd_reg_A = '0; fwd_reg_B = '0;
`endif
    @(posedge clk);
    #1;
    expect_wr("reset_wr", 1'b0, 5'd0, 64'h0); expect_hs("reset_hs", 1'b1, 1'b1, 1'b0); idle();
    reset = 1'b1;
    expect_wr("post_reset", 1'b0, 5'd0, 64'h0); idle();

    // ALU only
    expect_hs("alu_only_hs", 1'b1, 1'b1, 1'b0); go(1'b1, 5'd5, 64'hA5, 1'b0, 5'd0, 64'h0);
    expect_wr("alu_only_wr", 1'b1, 5'd5, 64'hA5); idle();

    // ALU and load in the same cycle
    expect_hs("conflict_hs", 1'b1, 1'b1, 1'b0); go(1'b1, 5'd3, 64'h11, 1'b1, 5'd4, 64'h22);
    expect_wr("conflict_c1", 1'b1, 5'd3, 64'h11); expect_hs("conflict_busy", 1'b1, 1'b1, 1'b1); idle();
    expect_wr("conflict_c2", 1'b1, 5'd4, 64'h22); expect_hs("conflict_drained", 1'b1, 1'b1, 1'b0); idle();

    // WAW against a queued load
    go(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'h1);
    expect_hs("waw_block", 1'b0, 1'b1, 1'b1); go(1'b1, 5'd7, 64'h2, 1'b0, 5'd0, 64'h0);
    expect_wr("waw_load_first", 1'b1, 5'd7, 64'h1); expect_hs("waw_release", 1'b1, 1'b1, 1'b0);
    go(1'b1, 5'd7, 64'h2, 1'b0, 5'd0, 64'h0);
    expect_wr("waw_alu_second", 1'b1, 5'd7, 64'h2); idle();

    // WAW against a load accepted in the same cycle
    expect_hs("waw_incoming", 1'b0, 1'b1, 1'b0); go(1'b1, 5'd8, 64'h3, 1'b1, 5'd8, 64'h4);
    expect_wr("idle_hold", 1'b0, 5'd7, 64'h2); expect_hs("waw_incoming_q", 1'b0, 1'b1, 1'b1);
    go(1'b1, 5'd8, 64'h3, 1'b0, 5'd0, 64'h0);
    expect_wr("waw_incoming_load", 1'b1, 5'd8, 64'h4); expect_hs("waw_incoming_rel", 1'b1, 1'b1, 1'b0);
    go(1'b1, 5'd8, 64'h3, 1'b0, 5'd0, 64'h0);
    expect_wr("waw_incoming_alu", 1'b1, 5'd8, 64'h3); idle();

    // Fill the FIFO with the ALU kept busy
    expect_hs("full_c0", 1'b1, 1'b1, 1'b0); go(1'b1, 5'd10, 64'hAA, 1'b1, 5'd11, 64'hB1);
    expect_wr("full_c1_wr", 1'b1, 5'd10, 64'hAA); expect_hs("full_c1", 1'b1, 1'b1, 1'b1);
    go(1'b1, 5'd13, 64'hC3, 1'b1, 5'd12, 64'hB2);
    expect_wr("full_c2_wr", 1'b1, 5'd13, 64'hC3); expect_hs("full_block", 1'b0, 1'b0, 1'b1);
    go(1'b1, 5'd14, 64'hD4, 1'b1, 5'd15, 64'hB3);
    expect_wr("full_pop1", 1'b1, 5'd11, 64'hB1); expect_hs("full_freed", 1'b1, 1'b1, 1'b1);
    go(1'b1, 5'd14, 64'hD4, 1'b1, 5'd15, 64'hB3);
    expect_wr("full_alu14", 1'b1, 5'd14, 64'hD4); expect_hs("full_again", 1'b0, 1'b0, 1'b1);
    go(1'b1, 5'd16, 64'hE6, 1'b0, 5'd0, 64'h0);
    expect_wr("full_pop2", 1'b1, 5'd12, 64'hB2); expect_hs("full_c5", 1'b1, 1'b1, 1'b1);
    go(1'b1, 5'd16, 64'hE6, 1'b0, 5'd0, 64'h0);
    expect_wr("full_alu16", 1'b1, 5'd16, 64'hE6); expect_hs("full_c6", 1'b1, 1'b1, 1'b1); idle();
    expect_wr("full_pop3", 1'b1, 5'd15, 64'hB3); expect_hs("full_done", 1'b1, 1'b1, 1'b0); idle();

    // x0 results complete without a strobe
    expect_hs("x0_alu_hs", 1'b1, 1'b1, 1'b0); go(1'b1, 5'd0, 64'h77, 1'b0, 5'd0, 64'h0);
    expect_wr("x0_alu", 1'b0, 5'd0, 64'h77); idle();
    go(1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 64'h55);
    idle();
    expect_wr("x0_mem", 1'b0, 5'd0, 64'h55); expect_hs("x0_mem_hs", 1'b1, 1'b1, 1'b0); idle();

    // Write r9, observed through the forwarding ports when present
`ifdef WB_FWD_EN
    fwd_reg_A = 5'd9; fwd_reg_B = 5'd3;
`endif
    go(1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'h0);
    expect_wr("r9_wr", 1'b1, 5'd9, 64'h99);
`ifdef WB_FWD_EN
    expect_fwd("fwd_r9", 1'b1, 1'b0, 64'h99);
`endif
    idle();

    // Reset with two loads queued
    go(1'b1, 5'd22, 64'h5, 1'b1, 5'd20, 64'h1);
    go(1'b1, 5'd23, 64'h6, 1'b1, 5'd21, 64'h2);
    alu_valid = 1'b0; mem_valid = 1'b0;
    #2 reset = 1'b0;
    expect_wr("midreset_wr", 1'b0, 5'd0, 64'h0); expect_hs("midreset_hs", 1'b1, 1'b1, 1'b0); idle();
    reset = 1'b1;
    expect_wr("release_wr", 1'b0, 5'd0, 64'h0); expect_hs("release_hs", 1'b1, 1'b1, 1'b0); idle();
    expect_wr("release_c2", 1'b0, 5'd0, 64'h0); expect_hs("release_hs2", 1'b1, 1'b1, 1'b0); idle();

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
